// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: state encoding and sizing helpers shared by the FIR codec sequencer
package fir_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, READ, FILTER, WAIT_WR, WRITE} state_t;
  localparam int SAMPLE_W = 24;
  function automatic int cnt_w(input int taps);
    return $clog2(taps) + 1;
  endfunction
endpackage

// File: rtl/fir_warmup_counter.sv
// fir_warmup_counter: saturating filtered-sample counter with warm flag (count >= TAPS-1)
module fir_warmup_counter import fir_ctrl_pkg::*; #(
  parameter int TAPS = 16,
  localparam int CW = cnt_w(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          warm_o
);
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = clr_i ? '0 : (inc_i && count_q != CW'(TAPS)) ? count_q + CW'(1) : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count_o = count_q;
  assign warm_o  = count_q >= CW'(TAPS - 1);
endmodule

// File: rtl/fir_codec_sequencer.sv
// fir_codec_sequencer: codec read -> filter -> write handshake FSM for two channel filters.
// Build option FIR_WARMUP_MUTE_EN zeroes outputs until the filter window has filled.
module fir_codec_sequencer import fir_ctrl_pkg::*; #(
  parameter int TAPS = 16,
  parameter int WIDTH = SAMPLE_W,
  localparam int CW = cnt_w(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_ready,
  input  logic             write_ready,
  input  logic [WIDTH-1:0] readdata_left,
  input  logic [WIDTH-1:0] readdata_right,
  input  logic             bypass,
  input  logic             flush,
  input  logic [WIDTH-1:0] filt_result_left,
  input  logic [WIDTH-1:0] filt_result_right,
  output logic             read,
  output logic             write,
  output logic             filt_en,
  output logic             filt_rst,
  output logic [WIDTH-1:0] filt_data_left,
  output logic [WIDTH-1:0] filt_data_right,
  output logic [WIDTH-1:0] writedata_left,
  output logic [WIDTH-1:0] writedata_right,
  output logic [CW-1:0]    sample_count,
  output logic             busy
);
`ifdef FIR_WARMUP_MUTE_EN
  localparam bit MUTE_EN = 1'b1;
`else
  localparam bit MUTE_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] hold_l_q, hold_r_q, wd_l_q, wd_r_q, wd_l_d, wd_r_d;
  logic byp_q, read_q, write_q, filt_en_q, warm;
  fir_warmup_counter #(.TAPS(TAPS)) u_cnt (
    .clk(clk), .rst(rst), .clr_i(flush), .inc_i(state_q == FILTER),
    .count_o(sample_count), .warm_o(warm)
  );
  always_comb begin
    state_d = IDLE;
    if (!flush)
      case (state_q)
        IDLE:    state_d = read_ready ? READ : IDLE;
        READ:    state_d = FILTER;
        FILTER:  state_d = WAIT_WR;
        WAIT_WR: state_d = write_ready ? WRITE : WAIT_WR;
        default: state_d = IDLE;
      endcase
    wd_l_d = byp_q ? hold_l_q : (MUTE_EN && !warm) ? '0 : filt_result_left;
    wd_r_d = byp_q ? hold_r_q : (MUTE_EN && !warm) ? '0 : filt_result_right;
  end
  // strobes are decoded from the next state so each is high exactly during its state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      filt_en_q <= 1'b0;
      byp_q     <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      wd_l_q    <= '0;
      wd_r_q    <= '0;
    end else begin
      state_q   <= state_d;
      read_q    <= state_d == READ;
      write_q   <= state_d == WRITE;
      filt_en_q <= state_d == FILTER;
      if (state_q == READ) begin
        hold_l_q <= readdata_left;
        hold_r_q <= readdata_right;
        byp_q    <= bypass;
      end
      if (state_q == FILTER && !flush) begin
        wd_l_q <= wd_l_d;
        wd_r_q <= wd_r_d;
      end
    end
  end
  assign read            = read_q;
  assign write           = write_q;
  assign filt_en         = filt_en_q;
  assign filt_rst        = rst | flush;
  assign filt_data_left  = hold_l_q;
  assign filt_data_right = hold_r_q;
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;
  assign busy            = state_q != IDLE;
endmodule

// File: tb/tb_fir_codec_sequencer.sv
// tb_fir_codec_sequencer: scoreboard bench with a moving-average filter stand-in.
module tb_fir_codec_sequencer;
  localparam int TAPS = 16;
  localparam int WIDTH = 24;
  localparam int LG = 4;
`ifdef FIR_WARMUP_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, read_ready = 1'b0, write_ready = 1'b0, bypass = 1'b0, flush = 1'b0;
  logic [WIDTH-1:0] readdata_left = '0, readdata_right = '0;
  logic signed [WIDTH-1:0] res_l, res_r;
  logic read, write, filt_en, filt_rst, busy;
  logic [WIDTH-1:0] filt_data_left, filt_data_right, writedata_left, writedata_right;
  logic [LG:0] sample_count;
  logic signed [WIDTH-1:0] hl [TAPS-1], hr [TAPS-1];
  int q_l[$], q_r[$];
  int n_cmp = 0, n_err = 0, nwr = 0, n_fe = 0;

  fir_codec_sequencer #(.TAPS(TAPS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .read_ready(read_ready), .write_ready(write_ready),
    .readdata_left(readdata_left), .readdata_right(readdata_right),
    .bypass(bypass), .flush(flush),
    .filt_result_left(res_l), .filt_result_right(res_r),
    .read(read), .write(write), .filt_en(filt_en), .filt_rst(filt_rst),
    .filt_data_left(filt_data_left), .filt_data_right(filt_data_right),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .sample_count(sample_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // filter stand-in: sum of the last TAPS samples, each pre-shifted by log2(TAPS)
  always_comb begin
    res_l = $signed(filt_data_left) >>> LG;
    res_r = $signed(filt_data_right) >>> LG;
    for (int i = 0; i < TAPS - 1; i++) begin
      res_l = res_l + hl[i];
      res_r = res_r + hr[i];
    end
  end
  always @(posedge clk) begin
    if (filt_rst) begin
      for (int i = 0; i < TAPS - 1; i++) begin
        hl[i] <= '0;
        hr[i] <= '0;
      end
    end else if (filt_en) begin
      hl[0] <= $signed(filt_data_left) >>> LG;
      hr[0] <= $signed(filt_data_right) >>> LG;
      for (int i = 1; i < TAPS - 1; i++) begin
        hl[i] <= hl[i-1];
        hr[i] <= hr[i-1];
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (read | write | filt_en) chk("strobe_onehot", $countones({read, write, filt_en}), 1);
    if (filt_en) n_fe++;
    if (write) begin
      nwr++;
      if (q_l.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        chk("writedata_left", int'($signed(writedata_left)), q_l.pop_front());
        chk("writedata_right", int'($signed(writedata_right)), q_r.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(input int target);
    int t = 0;
    while (nwr < target && t < 400) begin
      tick();
      t++;
    end
    chk("write_count", nwr, target);
  endtask

  task automatic run_txn(input int l, input int r, input bit byp, input int el, input int er);
    int target;
    target = nwr + 1;
    q_l.push_back(el);
    q_r.push_back(er);
    readdata_left = WIDTH'(l);
    readdata_right = WIDTH'(r);
    bypass = byp;
    read_ready = 1'b1;
    tick();
    read_ready = 1'b0;
    wait_writes(target);
    bypass = 1'b0;
  endtask

  initial begin
    int snap;
    tick();
    tick();
    chk("rst_strobes", int'({read, write, filt_en, busy}), 0);
    chk("rst_count", int'(sample_count), 0);
    chk("rst_wd", int'(writedata_left | writedata_right | filt_data_left), 0);
    chk("rst_filt_rst", int'(filt_rst), 1);
    rst = 1'b0;
    // constant 50 stream: window fills over 16 samples, settling at 16*3 = 48
    readdata_left = 24'd50;
    readdata_right = 24'd50;
    write_ready = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      int e;
      e = (n >= TAPS) ? 48 : (MUTE ? 0 : 3 * n);
      q_l.push_back(e);
      q_r.push_back(e);
    end
    read_ready = 1'b1;
    wait_writes(18);
    read_ready = 1'b0;
    chk("sat_count", int'(sample_count), TAPS);
    // write back-pressure holds the FSM in WAIT_WR
    write_ready = 1'b0;
    read_ready = 1'b1;
    tick();
    read_ready = 1'b0;
    chk("read_pulse", int'(read), 1);
    tick();
    chk("filt_en_pulse", int'(filt_en), 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("wait_wr_hold", int'({read, write, filt_en, busy}), 1);
      tick();
    end
    q_l.push_back(48);
    q_r.push_back(48);
    snap = nwr + 1;
    write_ready = 1'b1;
    wait_writes(snap);
    tick();
    tick();
    chk("idle_after_wr", int'({read, busy}), 0);
    // flush in WAIT_WR drops the pending write
    write_ready = 1'b0;
    read_ready = 1'b1;
    tick();
    read_ready = 1'b0;
    tick();
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("flush_filt_rst", int'(filt_rst), 1);
    tick();
    flush = 1'b0;
    chk("flush_busy", int'(busy), 0);
    chk("flush_count", int'(sample_count), 0);
    chk("flush_wd_kept", int'(writedata_left), 48);
    write_ready = 1'b1;
    run_txn(50, 50, 1'b0, MUTE ? 0 : 3, MUTE ? 0 : 3);
    chk("post_flush_count", int'(sample_count), 1);
    // bypass returns raw samples yet still advances the filter
    snap = n_fe;
    run_txn(60, 40, 1'b1, 60, 40);
    chk("bypass_count", int'(sample_count), 2);
    chk("bypass_filt_en", n_fe, snap + 1);
    // reset in FILTER aborts the transaction
    readdata_left = 24'd50;
    readdata_right = 24'd50;
    read_ready = 1'b1;
    tick();
    read_ready = 1'b0;
    tick();
    chk("pre_rst_filter", int'(filt_en), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_strobes", int'({read, write, filt_en, busy}), 0);
    chk("rst_mid_count", int'(sample_count), 0);
    chk("rst_mid_wd", int'(writedata_left | writedata_right), 0);
    run_txn(50, 50, 1'b0, MUTE ? 0 : 3, MUTE ? 0 : 3);
    chk("sb_empty", q_l.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
